// File: rtl/debounce_pkg.sv
// Shared constants, types and helpers for the debounce_bank slice.
// The quadrature decoder types are used only when DEBOUNCE_QUAD_EN is defined.
package debounce_pkg;

    localparam int unsigned DEB_DEFAULT_CNT = 167;

    // Encoder contact pair {A,B}, named in Gray order
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic quad_state_t gray_fwd(input quad_state_t s);
        quad_state_t nxt;
        case (s)
            Q00:     nxt = Q01;
            Q01:     nxt = Q11;
            Q11:     nxt = Q10;
            default: nxt = Q00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single debounce channel: 2-flop synchroniser, stability counter,
// registered clean level with one-cycle rise/fall strobes and busy flag.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEB_DEFAULT_CNT,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int unsigned      CNT_W    = clog2_min1(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             r_s0;
    logic             r_s1;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_accept;

    always_comb begin
        w_diff   = r_s1 ^ r_dout;
        w_accept = w_diff && (r_cnt == CNT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0   <= RST_VAL;
            r_s1   <= RST_VAL;
            r_dout <= RST_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s0   <= i_din;
            r_s1   <= r_s0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any sample matching the clean level restarts the count
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_dout <= r_s1;
                r_cnt  <= '0;
                r_rise <= r_s1;
                r_fall <= ~r_s1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_dout = r_dout;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer bank. Optional quadrature decoder on dout[1:0]
// is built when DEBOUNCE_QUAD_EN is defined (needs CH >= 2).
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CH      = 2,
    parameter int unsigned CNT_MAX = DEB_DEFAULT_CNT,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] busy
`ifdef DEBOUNCE_QUAD_EN
    ,
    output logic          qstep,
    output logic          qdir,
    output logic          qerr
`endif
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        debounce_chan #(
            .CNT_MAX (CNT_MAX),
            .RST_VAL (RST_VAL)
        ) u_chan (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_din  (din[g]),
            .o_dout (dout[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g]),
            .o_busy (busy[g])
        );
    end

`ifdef DEBOUNCE_QUAD_EN
    quad_state_t r_ab_prev;
    quad_state_t w_ab_now;
    logic [1:0]  w_delta;
    logic        w_single;
    logic        w_fwd;
    logic        r_qstep;
    logic        r_qdir;
    logic        r_qerr;

    // A is channel 0, B is channel 1; pair packed as {A,B}
    always_comb begin
        w_ab_now = quad_state_t'({dout[0], dout[1]});
        w_delta  = w_ab_now ^ r_ab_prev;
        w_single = (w_delta == 2'b01) || (w_delta == 2'b10);
        w_fwd    = (w_ab_now == gray_fwd(r_ab_prev));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ab_prev <= quad_state_t'({RST_VAL, RST_VAL});
            r_qstep   <= 1'b0;
            r_qdir    <= 1'b0;
            r_qerr    <= 1'b0;
        end else begin
            r_ab_prev <= w_ab_now;
            r_qstep   <= w_single;
            r_qerr    <= (w_delta == 2'b11);
            if (w_single) begin
                r_qdir <= w_fwd;
            end
        end
    end

    assign qstep = r_qstep;
    assign qdir  = r_qdir;
    assign qerr  = r_qerr;
`endif

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised N-channel debouncer for buttons and rotary-encoder contacts. Each channel has a 2-flop synchroniser, its own stability counter, a registered clean level, and one-cycle rise/fall strobes. It replaces fixed two-input debouncers that share one counter. It sits between the pad inputs and the control FSMs; the optional quadrature decoder drives encoder consumers directly.

Parameters:
CH, 2, number of independent channels (>=1)
CNT_MAX, 167, consecutive cycles a new synchronised level must persist before acceptance (>=1)
RST_VAL, 0, reset level of every clean output, and of the synchroniser flops (1-bit, replicated)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
din  in  CH  raw asynchronous inputs
dout  out  CH  debounced level per channel
rise  out  CH  one-cycle strobe, dout went 0->1
fall  out  CH  one-cycle strobe, dout went 1->0
busy  out  CH  channel counter nonzero (a change is pending)

Behaviour:
- Reset (rst=1 at edge): sync flops=RST_VAL, dout=RST_VAL, cnt=0, rise=fall=0, busy=0. Reset dominates all other activity; reset mid-count discards the pending change.
- Sync: s0<=din[i]; s1<=s0. s1 is the only value the counter logic uses.
- Counter width CNT_W=max(1,$clog2(CNT_MAX)) (localparam).
- Per edge, per channel:
  - s1==dout: cnt<=0. Any glitch restarts the count.
  - s1!=dout, cnt<CNT_MAX-1: cnt<=cnt+1.
  - s1!=dout, cnt==CNT_MAX-1: dout<=s1; cnt<=0; rise<=s1; fall<=~s1.
- rise/fall are registered and high for exactly one cycle, coincident with the dout change. Otherwise they are 0.
- Latency: din held stable from before edge k (s0 captures at k) -> dout changes at edge k+1+CNT_MAX.
- CNT_MAX=1: dout follows s1 one cycle later; cnt stays 0.
- Channels are fully independent. Simultaneous changes on several channels each produce their own strobes in the same cycle.
- busy = (cnt!=0), combinational from cnt.

Optional Feature:
Macro DEBOUNCE_QUAD_EN.
- Defined (requires CH>=2): adds ports qstep(out,1), qdir(out,1), qerr(out,1). They decode the debounced pair A=dout[0], B=dout[1].
  - On a cycle where exactly one of A/B changed, the new AB is compared against the previous AB in Gray order 00->01->11->10->00.
  - Forward transition: qstep=1, qdir=1. Reverse transition: qstep=1, qdir=0.
  - Both changed in the same cycle: qerr=1, qstep=0.
  - qstep/qerr are registered, one-cycle strobes, asserted one cycle after the dout change. qdir holds its last value.
  - Reset: all three outputs 0.
- Undefined: these ports and their logic do not exist; the base block is unchanged.

Decomposition:
- Package debounce_pkg:
  - function clog2_min1(n) for CNT_W.
  - Constant DEB_DEFAULT_CNT=167.
  - Typedef quad_state_t for the 2-bit Gray pair with named values Q00/Q01/Q11/Q10.
- One sub-module, debounce_chan: synchroniser, counter, dout/rise/fall/busy for a single channel.
- debounce_bank instantiates CH copies in a generate loop and adds the quadrature logic under the macro.

Test Plan:
- CH=2, CNT_MAX=4. Reset, then din=2'b01 held, s0 capturing at edge k -> dout[0]=1 at edge k+5; rise[0]=1 that cycle only; fall=0; dout[1]=0 throughout.
- Glitch: din[0] 0->1 for 3 cycles, then back to 0 -> dout[0] stays 0, no strobe, busy[0] high and then clears to 0.
- Simultaneous: both channels 0->1 on the same edge -> rise=2'b11 in one cycle. Both 1->0 later -> fall=2'b11.
- Reset mid-count: rst=1 when cnt=2 -> next cycle cnt=0, busy=0, dout=RST_VAL. After release the full 1+CNT_MAX latency is required again.
- CNT_MAX=1, RST_VAL=1: after reset dout=2'b11. din[1]=0 captured at edge k -> dout[1]=0 and fall[1]=1 at edge k+2.
- DEBOUNCE_QUAD_EN: AB sequence 00->01->11->10->00 -> four qstep pulses with qdir=1. Reverse sequence -> qdir=0. Forcing A and B to change in the same cycle -> qerr=1, no qstep.
